// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and defaults for the register file sequencer
package register_file_pkg;

  localparam int LEN_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    RDRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/read_output_stage.sv
// rtl/read_output_stage.sv - one-entry holding register for the read-data stream
module read_output_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  // A load always wins over a drain, so a beat consumed this cycle is replaced seamlessly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - register array with one synchronous write port and a combinational read port
module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] regs_q [2**DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/register_file_sequencer.sv
// rtl/register_file_sequencer.sv - turns burst commands into register file beats and streams
module register_file_sequencer
  import register_file_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             cmdWrite,
  input  logic [DEPTH-1:0] cmdAddr,
  input  logic [LEN_W-1:0] cmdLen,
  input  logic             wrValid,
  output logic             wrReady,
  input  logic [WIDTH-1:0] wrData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic [WIDTH-1:0] rdData,
  output logic             rdLast,
  output logic             rfWriteEnable,
  output logic [DEPTH-1:0] rfWriteAddr,
  output logic [WIDTH-1:0] rfWriteData,
  output logic [DEPTH-1:0] rfReadAddr,
  input  logic [WIDTH-1:0] rfReadData,
  output logic             busy
);

  state_e           state_q;
  logic [DEPTH-1:0] addr_q;
  logic [LEN_W-1:0] cnt_q;

  logic wr_fire;
  logic rd_load;
  logic last_beat;

  assign last_beat = (cnt_q == '0);
  assign wr_fire   = wrValid && (state_q == WRITE);
  assign rd_load   = (state_q == READ) && (!rdValid || rdReady);

  // cnt_q holds the beats remaining after the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmdValid) begin
            addr_q  <= cmdAddr;
            cnt_q   <= cmdLen;
            state_q <= cmdWrite ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            addr_q <= addr_q + DEPTH'(1);
            if (last_beat) state_q <= IDLE;
            else           cnt_q   <= cnt_q - LEN_W'(1);
          end
        end
        READ: begin
          if (rd_load) begin
            addr_q <= addr_q + DEPTH'(1);
            if (last_beat) state_q <= RDRAIN;
            else           cnt_q   <= cnt_q - LEN_W'(1);
          end
        end
        RDRAIN: begin
          if (rdValid && rdReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmdReady      = (state_q == IDLE);
  assign wrReady       = (state_q == WRITE);
  assign busy          = (state_q != IDLE);
  assign rfWriteEnable = wr_fire;
  assign rfWriteAddr   = addr_q;
  assign rfWriteData   = wr_fire ? wrData : '0;
  assign rfReadAddr    = addr_q;

  read_output_stage #(
    .WIDTH (WIDTH)
  ) u_read_output_stage (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (rd_load),
    .data_i  (rfReadData),
    .last_i  (last_beat),
    .ready_i (rdReady),
    .valid_o (rdValid),
    .data_o  (rdData),
    .last_o  (rdLast)
  );

endmodule

// File: tb/tb_register_file_sequencer.sv
// tb/tb_register_file_sequencer.sv - self-checking bench for register_file_sequencer
module tb_register_file_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int LEN_W = 4;
  localparam int NREG  = 2**DEPTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmdValid, cmdReady, cmdWrite;
  logic [DEPTH-1:0] cmdAddr;
  logic [LEN_W-1:0] cmdLen;
  logic             wrValid, wrReady;
  logic [WIDTH-1:0] wrData;
  logic             rdValid, rdReady, rdLast;
  logic [WIDTH-1:0] rdData;
  logic             rfWriteEnable;
  logic [DEPTH-1:0] rfWriteAddr, rfReadAddr;
  logic [WIDTH-1:0] rfWriteData, rfReadData;
  logic             busy;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] mem [NREG];

  always #5 clk = ~clk;

  register_file_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdLen(cmdLen),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .rdLast(rdLast),
    .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
    .rfReadAddr(rfReadAddr), .rfReadData(rfReadData), .busy(busy)
  );

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
    .clk_i(clk), .we_i(rfWriteEnable), .waddr_i(rfWriteAddr), .wdata_i(rfWriteData),
    .raddr_i(rfReadAddr), .rdata_o(rfReadData)
  );

  typedef struct {
    int addr;
    int len;
    int base;
    int gap_at;
    int rd_mode;
    int exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered on a falling edge; returns on the falling edge after the handshake.
  task automatic send_cmd(input bit w, input int a, input int l);
    int t = 0;
    cmdValid = 1'b1;
    cmdWrite = w;
    cmdAddr  = DEPTH'(a);
    cmdLen   = LEN_W'(l);
    #1;
    while (!cmdReady && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("cmd_accept", 32'(cmdReady), 32'd1);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic write_collect(input int a, input int l, input int base, input int gap_at,
                               output int cycles);
    int i = 0;
    int gap = 0;
    cycles = 0;
    while (i <= l && cycles < 200) begin
      wrValid = !(i == gap_at && gap < 2);
      wrData  = WIDTH'(base + i);
      #1;
      chk("wr_enable", 32'(rfWriteEnable), 32'(wrValid));
      chk("wr_ready", 32'(wrReady), 32'd1);
      if (wrValid) begin
        chk("wr_addr", 32'(rfWriteAddr), 32'((a + i) % NREG));
        chk("wr_data", rfWriteData, 32'(base + i));
        mem[(a + i) % NREG] = WIDTH'(base + i);
        i++;
      end else begin
        gap++;
      end
      cycles++;
      @(negedge clk);
    end
    wrValid = 1'b0;
    chk("wr_complete", 32'(i), 32'(l + 1));
    #1;
    chk("wr_idle_busy", 32'(busy), 32'd0);
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic read_collect(input int a, input int l, input int mode);
    int k = 0;
    int cyc = 1;
    bit seen = 0;
    bit stalled = 0;
    logic [WIDTH-1:0] held = '0;
    logic held_last = 1'b0;
    while (k <= l && cyc < 300) begin
      rdReady = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        chk("rd_hold_data", rdData, held);
        chk("rd_hold_last", 32'(rdLast), 32'(held_last));
        chk("rd_hold_valid", 32'(rdValid), 32'd1);
      end
      if (rdValid && !seen) begin
        seen = 1;
        chk("rd_first_cycle", 32'(cyc), 32'd2);
      end
      if (rdValid && rdReady) begin
        chk("rd_data", rdData, mem[(a + k) % NREG]);
        chk("rd_last", 32'(rdLast), 32'(k == l));
        k++;
      end
      stalled   = rdValid && !rdReady;
      held      = rdData;
      held_last = rdLast;
      @(negedge clk);
      cyc++;
    end
    rdReady = 1'b0;
    chk("rd_complete", 32'(k), 32'(l + 1));
    #1;
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_valid", 32'(rdValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int cyc;
    int beats;
    int t;

    vecs[0] = '{addr: 0,  len: 15, base: 'h100, gap_at: -1, rd_mode: 0, exp_cycles: 16};
    vecs[1] = '{addr: 16, len: 15, base: 'h200, gap_at: -1, rd_mode: 0, exp_cycles: 16};
    vecs[2] = '{addr: 4,  len: 3,  base: 'hA0,  gap_at: -1, rd_mode: 0, exp_cycles: 4};
    vecs[3] = '{addr: 30, len: 3,  base: 'h30,  gap_at: -1, rd_mode: 0, exp_cycles: 4};
    vecs[4] = '{addr: 8,  len: 5,  base: 'h50,  gap_at: 2,  rd_mode: 1, exp_cycles: 8};
    vecs[5] = '{addr: 31, len: 0,  base: 'h77,  gap_at: -1, rd_mode: 1, exp_cycles: 1};

    reset    = 1'b0;
    cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
    wrValid  = 1'b1; wrData = 32'hDEAD_BEEF; rdReady = 1'b0;

    @(negedge clk); #1;
    chk("rst_cmd_ready", 32'(cmdReady), 32'd1);
    chk("rst_wr_ready", 32'(wrReady), 32'd0);
    chk("rst_wr_enable", 32'(rfWriteEnable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_addr", 32'(rfWriteAddr), 32'd0);
    chk("rst_rd_addr", 32'(rfReadAddr), 32'd0);
    chk("rst_wr_data", rfWriteData, 32'd0);
    chk("rst_rd_valid", 32'(rdValid), 32'd0);
    chk("rst_rd_data", rdData, 32'd0);
    chk("rst_rd_last", 32'(rdLast), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_wr_ignored", 32'(rfWriteEnable), 32'd0);
    wrValid = 1'b0;
    chk("post_rst_cmd_ready", 32'(cmdReady), 32'd1);

    for (int v = 0; v < 6; v++) begin
      send_cmd(1'b1, vecs[v].addr, vecs[v].len);
      write_collect(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].gap_at, cyc);
      chk("wr_cycles", 32'(cyc), 32'(vecs[v].exp_cycles));
      send_cmd(1'b0, vecs[v].addr, vecs[v].len);
      read_collect(vecs[v].addr, vecs[v].len, vecs[v].rd_mode);
    end

    // A command offered during a write burst waits until the burst ends.
    send_cmd(1'b1, 10, 3);
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 5'd10; cmdLen = 4'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("busy_cmd_ready", 32'(cmdReady), 32'd0);
      chk("busy_busy", 32'(busy), 32'd1);
      chk("busy_no_write", 32'(rfWriteEnable), 32'd0);
      @(negedge clk);
    end
    write_collect(10, 3, 'hC0, -1, cyc);
    chk("pending_cmd_ready", 32'(cmdReady), 32'd1);
    @(negedge clk);
    cmdValid = 1'b0;
    read_collect(10, 3, 0);

    // Reset in the middle of an 8-beat read.
    send_cmd(1'b0, 0, 7);
    rdReady = 1'b1;
    beats = 0;
    t = 0;
    while (beats < 2 && t < 50) begin
      #1;
      if (rdValid) begin
        chk("abort_rd_data", rdData, mem[beats]);
        beats++;
      end
      @(negedge clk);
      t++;
    end
    chk("abort_beats", 32'(beats), 32'd2);
    reset = 1'b0;
    wrValid = 1'b1;
    #1;
    chk("abort_rd_valid", 32'(rdValid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmdReady), 32'd1);
    chk("abort_rd_addr", 32'(rfReadAddr), 32'd0);
    chk("abort_wr_data", rfWriteData, 32'd0);
    chk("abort_wr_enable", 32'(rfWriteEnable), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wrValid = 1'b0;
    rdReady = 1'b0;
    #1;
    chk("abort_release_ready", 32'(cmdReady), 32'd1);
    send_cmd(1'b0, 4, 3);
    read_collect(4, 3, 0);

    for (int r = 0; r < 24; r++) begin
      int a, l, g;
      a = int'($urandom_range(0, NREG - 1));
      l = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        g = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, l));
        send_cmd(1'b1, a, l);
        write_collect(a, l, int'($urandom), g, cyc);
        chk("rand_wr_cycles", 32'(cyc), 32'(l + 1 + ((g >= 0) ? 2 : 0)));
      end else begin
        send_cmd(1'b0, a, l);
        read_collect(a, l, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
